alu_sched: RTL and testbench

- Shares one combinational 8-bit ALU instance between two requesters: port 0 is the core pipeline, port 1 is an auxiliary engine (e.g. a memory-scan helper).
- Arbitrates round-robin and drives the ALU from registered operands.
- Captures result and branch flag, and returns them on a valid/ready response channel.
- Sits between the requesters and the ALU; the ALU itself is instantiated outside this block.

---
 rtl/alu_sched_pkg.sv | 22 ++
 rtl/alu_sched_rr_arb2.sv | 42 ++++
 rtl/alu_sched.sv | 176 +++++++++++++++++
 tb/tb_alu_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// ----------------------------------------------------------------------------
// alu_sched_pkg
// Shared definitions for the ALU request scheduler:
//   - state_t      : scheduler FSM states (IDLE, EXEC, RESP)
//   - ALU_CMD_EQ/LT: the two ALU commands whose branch flag is meaningful
//   - DEF_DW/DEF_CW: default operand and command widths
// ----------------------------------------------------------------------------
package alu_sched_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_CW = 4;

    localparam logic [3:0] ALU_CMD_EQ = 4'b1101;
    localparam logic [3:0] ALU_CMD_LT = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_sched_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way combinational grant logic.
//   req[1:0] : request bits
//   ptr      : favoured requester when both request (round-robin build)
//   gnt[1:0] : one-hot grant, 00 when nothing requests
// Build option: ALU_FIXED_PRIO_EN selects fixed priority (requester 0 wins
// ties) and leaves ptr unused.
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

`ifdef ALU_FIXED_PRIO_EN
    // Pointer has no meaning with fixed priority; kept for a common port list.
    logic w_unused_ptr;
    assign w_unused_ptr = ptr;

    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`else
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave it unassigned and infer a latch.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end
`endif

endmodule

// File: rtl/alu_sched.sv
// ----------------------------------------------------------------------------
// alu_sched
// Shares one external combinational ALU between requester 0 (core pipeline)
// and requester 1 (auxiliary engine). A request is accepted in IDLE, its
// operands are registered onto the ALU ports, the result and branch flag are
// captured one cycle later, and a response is held until the granted
// requester takes it.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready [1:0]  request handshake, bit i = requester i
//   req_cmd0/1, req_a0/1, req_b0/1  request payload per requester
//   rsp_valid [1:0], rsp_ready [1:0]  response handshake per requester
//   rsp_rslt, rsp_one          shared response data, qualified by rsp_valid
//   alu_cmd, alu_inA, alu_inB  registered drive to the external ALU
//   alu_rslt, alu_one          external ALU result and branch flag
//
// Build option: ALU_FIXED_PRIO_EN -> requester 0 always wins ties and the
// round-robin pointer is removed. Default build is round-robin.
// ----------------------------------------------------------------------------
module alu_sched
    import alu_sched_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [CW-1:0] req_cmd0,
    input  logic [CW-1:0] req_cmd1,
    input  logic [DW-1:0] req_a0,
    input  logic [DW-1:0] req_a1,
    input  logic [DW-1:0] req_b0,
    input  logic [DW-1:0] req_b1,
    output logic [1:0]    rsp_valid,
    input  logic [1:0]    rsp_ready,
    output logic [DW-1:0] rsp_rslt,
    output logic          rsp_one,
    output logic [CW-1:0] alu_cmd,
    output logic [DW-1:0] alu_inA,
    output logic [DW-1:0] alu_inB,
    input  logic [DW-1:0] alu_rslt,
    input  logic          alu_one
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_gnt;          // index of the requester being served
    logic [CW-1:0] r_alu_cmd;
    logic [DW-1:0] r_alu_inA;
    logic [DW-1:0] r_alu_inB;
    logic [DW-1:0] r_rsp_rslt;
    logic          r_rsp_one;
    logic [1:0]    r_rsp_valid;

    logic [1:0]    w_gnt;
    logic          w_ptr;
    logic          w_accept;
    logic          w_handshake;
    logic          w_is_cmp;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef ALU_FIXED_PRIO_EN
    assign w_ptr = 1'b0;
`else
    logic r_rr_ptr;

    // Pointer moves only when a response completes, so a requester that is
    // accepted but not yet answered is not skipped over.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (w_handshake) begin
            r_rr_ptr <= ~r_gnt;
        end
    end

    assign w_ptr = r_rr_ptr;
`endif

    rr_arb2 u_arb (
        .req (req_valid),
        .ptr (w_ptr),
        .gnt (w_gnt)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 2'b00;
        w_accept    = 1'b0;
        w_handshake = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = w_gnt;
                if (w_gnt != 2'b00) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                // Only the granted requester's ready bit completes the response.
                if (rsp_ready[r_gnt]) begin
                    w_handshake = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The ALU branch flag is undefined for non-compare commands; masking it
    // keeps an X from ever reaching rsp_one.
    assign w_is_cmp = (r_alu_cmd == CW'(ALU_CMD_EQ)) || (r_alu_cmd == CW'(ALU_CMD_LT));

    // ------------------------------------------------------------------
    // Operand and response registers
    // ------------------------------------------------------------------
    // NOTE: all data registers are reset because they are visible outputs
    // with defined reset values; a reset mid-operation also discards it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt       <= 1'b0;
            r_alu_cmd   <= '0;
            r_alu_inA   <= '0;
            r_alu_inB   <= '0;
            r_rsp_rslt  <= '0;
            r_rsp_one   <= 1'b0;
            r_rsp_valid <= 2'b00;
        end else begin
            if (w_accept) begin
                r_gnt     <= w_gnt[1];
                r_alu_cmd <= w_gnt[1] ? req_cmd1 : req_cmd0;
                r_alu_inA <= w_gnt[1] ? req_a1   : req_a0;
                r_alu_inB <= w_gnt[1] ? req_b1   : req_b0;
            end
            if (r_state == EXEC) begin
                r_rsp_rslt  <= alu_rslt;
                r_rsp_one   <= w_is_cmp ? alu_one : 1'b0;
                r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
            end
            if (w_handshake) begin
                r_rsp_valid <= 2'b00;
            end
        end
    end

    assign alu_cmd   = r_alu_cmd;
    assign alu_inA   = r_alu_inA;
    assign alu_inB   = r_alu_inB;
    assign rsp_rslt  = r_rsp_rslt;
    assign rsp_one   = r_rsp_one;
    assign rsp_valid = r_rsp_valid;

endmodule

// File: tb/tb_alu_sched.sv
// ----------------------------------------------------------------------------
// tb_alu_sched
// Self-checking bench for alu_sched. Provides a behavioural ALU on the ALU
// ports, applies a table of directed operations, reset-in-EXEC and
// contention sequences, then randomized traffic predicted by a
// transaction-level model (grant choice, result, branch flag, latency).
// ----------------------------------------------------------------------------
module tb_alu_sched;
    import alu_sched_pkg::*;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [CW-1:0] req_cmd0, req_cmd1;
    logic [DW-1:0] req_a0, req_a1, req_b0, req_b1;
    logic [1:0]    rsp_valid;
    logic [1:0]    rsp_ready;
    logic [DW-1:0] rsp_rslt;
    logic          rsp_one;
    logic [CW-1:0] alu_cmd;
    logic [DW-1:0] alu_inA, alu_inB;
    logic [DW-1:0] alu_rslt;
    logic          alu_one;

    always #5 clk = ~clk;

    alu_sched #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd0  (req_cmd0),
        .req_cmd1  (req_cmd1),
        .req_a0    (req_a0),
        .req_a1    (req_a1),
        .req_b0    (req_b0),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rslt  (rsp_rslt),
        .rsp_one   (rsp_one),
        .alu_cmd   (alu_cmd),
        .alu_inA   (alu_inA),
        .alu_inB   (alu_inB),
        .alu_rslt  (alu_rslt),
        .alu_one   (alu_one)
    );

    // Behavioural ALU: add/sub/and/or/xor/eq/lt, anything else returns ~a.
    function automatic logic [7:0] alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b1000: return a ^ b;
            4'b1101: return {7'd0, a == b};
            4'b1110: return {7'd0, a < b};
            default: return ~a;
        endcase
    endfunction

    // Expected branch flag: meaningful only for eq/lt, zero otherwise.
    function automatic logic flag_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        if (c == ALU_CMD_EQ) return a == b;
        if (c == ALU_CMD_LT) return a < b;
        return 1'b0;
    endfunction

    // The ALU drives garbage (1) on its flag for non-compare commands.
    assign alu_rslt = alu_f(alu_cmd, alu_inA, alu_inB);
    assign alu_one  = ((alu_cmd == ALU_CMD_EQ) || (alu_cmd == ALU_CMD_LT)) ? alu_rslt[0] : 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int favor    = 0;   // model: requester favoured on a tie

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
`ifdef ALU_FIXED_PRIO_EN
        return 0;
`else
        return favor;
`endif
    endfunction

    // One full operation: accept, EXEC, RESP held for 'hold' cycles, handshake.
    // Called right after a falling edge with the DUT expected in IDLE.
    task automatic transact(input logic [1:0] v,
                            input logic [3:0] c0, input logic [7:0] a0, input logic [7:0] b0,
                            input logic [3:0] c1, input logic [7:0] a1, input logic [7:0] b1,
                            input int hold, input int exp_g,
                            input logic [7:0] exp_rslt, input logic exp_one, input string tag);
        logic [1:0] gmask;
        logic [3:0] ec;
        logic [7:0] ea, eb;
        gmask = (exp_g == 1) ? 2'b10 : 2'b01;
        ec    = (exp_g == 1) ? c1 : c0;
        ea    = (exp_g == 1) ? a1 : a0;
        eb    = (exp_g == 1) ? b1 : b0;
        req_valid = v;
        req_cmd0 = c0; req_a0 = a0; req_b0 = b0;
        req_cmd1 = c1; req_a1 = a1; req_b1 = b1;
        rsp_ready = 2'b00;
        #1;
        check({tag, " accept req_ready"}, 32'(req_ready), 32'(gmask));
        @(posedge clk); @(negedge clk);
        // The losing requester (if any) keeps asking during EXEC.
        req_valid = v & ~gmask;
        #1;
        check({tag, " exec ready/valid"}, 32'({req_ready, rsp_valid}), 32'(4'b0000));
        check({tag, " exec alu operands"}, 32'({alu_cmd, alu_inA, alu_inB}), 32'({ec, ea, eb}));
        @(posedge clk); @(negedge clk);
        // Both requesting and the other ready bit high must not matter in RESP.
        req_valid = 2'b11;
        rsp_ready = ~gmask;
        #1;
        check({tag, " resp"}, 32'({rsp_valid, rsp_rslt, rsp_one, req_ready}),
              32'({gmask, exp_rslt, exp_one, 2'b00}));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk); #1;
            check({tag, " resp hold"}, 32'({rsp_valid, rsp_rslt, rsp_one, req_ready}),
                  32'({gmask, exp_rslt, exp_one, 2'b00}));
        end
        req_valid = 2'b00;
        rsp_ready = gmask;
        @(posedge clk); @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        check({tag, " after handshake rsp_valid"}, 32'(rsp_valid), 32'(2'b00));
        favor = 1 - exp_g;
    endtask

    typedef struct {
        logic [1:0] v;
        logic [3:0] c;
        logic [7:0] a;
        logic [7:0] b;
        int         hold;
        int         g;
        logic [7:0] rslt;
        logic       one;
    } vec_t;

    vec_t       tbl[7];
    logic [3:0] cmds[7] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b1000, 4'b1101, 4'b1110};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] v;
        logic [3:0] c0, c1;
        logic [7:0] a0, a1, b0, b1;
        int         g;

        tbl[0] = '{2'b01, 4'b0000, 8'd20,  8'd22,  0,  0, 8'd42,  1'b0};
        tbl[1] = '{2'b10, 4'b1110, 8'd3,   8'd9,   0,  1, 8'd1,   1'b1};
        tbl[2] = '{2'b10, 4'b1101, 8'd5,   8'd6,   1,  1, 8'd0,   1'b0};
        tbl[3] = '{2'b01, 4'b1000, 8'hF0,  8'h3C,  10, 0, 8'hCC,  1'b0};
        tbl[4] = '{2'b10, 4'b1101, 8'd7,   8'd7,   2,  1, 8'd1,   1'b1};
        tbl[5] = '{2'b01, 4'b0001, 8'd5,   8'd6,   0,  0, 8'hFF,  1'b0};
        tbl[6] = '{2'b10, 4'b1110, 8'd200, 8'd200, 0,  1, 8'd0,   1'b0};

        reset = 1'b1;
        req_valid = 2'b00; rsp_ready = 2'b00;
        req_cmd0 = '0; req_cmd1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("reset outputs", 32'({req_ready, rsp_valid, rsp_rslt, rsp_one, alu_cmd, alu_inA, alu_inB}), 32'(0));
        reset = 1'b0;

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            transact(tbl[i].v, tbl[i].c, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].a, tbl[i].b,
                     tbl[i].hold, tbl[i].g, tbl[i].rslt, tbl[i].one, $sformatf("vec%0d", i));
        end

        // Reset while in EXEC: the op is dropped and the pointer returns to 0.
        transact(2'b01, 4'b0000, 8'd1, 8'd1, 4'b0000, 8'd0, 8'd0, 0, 0, 8'd2, 1'b0, "pre-reset");
        req_valid = 2'b01; req_cmd0 = 4'b0101; req_a0 = 8'h0F; req_b0 = 8'hF0;
        @(posedge clk); @(negedge clk);
        req_valid = 2'b00;
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset in exec outputs", 32'({req_ready, rsp_valid, rsp_rslt, rsp_one, alu_cmd, alu_inA, alu_inB}), 32'(0));
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk); #1;
            check("no response after reset", 32'(rsp_valid), 32'(2'b00));
        end
        rsp_ready = 2'b00;
        favor = 0;

        // Contention right after reset: 0,1,0,1 round-robin (0,0,0,0 fixed).
        for (int i = 0; i < 4; i++) begin
            g = model_grant(2'b11);
`ifdef ALU_FIXED_PRIO_EN
            check("contention grant", 32'(g), 32'(0));
`else
            check("contention grant", 32'(g), 32'(i % 2));
`endif
            a0 = 8'(i * 16 + 1);
            a1 = 8'(i * 16 + 2);
            transact(2'b11, 4'b0000, a0, 8'd1, 4'b1000, a1, 8'hFF, 0, g,
                     (g == 1) ? (a1 ^ 8'hFF) : (a0 + 8'd1), 1'b0, $sformatf("contend%0d", i));
        end

        // Randomized traffic against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            v  = 2'($urandom_range(1, 3));
            c0 = cmds[$urandom_range(0, 6)];
            c1 = cmds[$urandom_range(0, 6)];
            a0 = 8'($urandom); b0 = 8'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) b0 = a0;
            g  = model_grant(v);
            transact(v, c0, a0, b0, c1, a1, b1, $urandom_range(0, 3), g,
                     (g == 1) ? alu_f(c1, a1, b1) : alu_f(c0, a0, b0),
                     (g == 1) ? flag_f(c1, a1, b1) : flag_f(c0, a0, b0),
                     $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
